// File: rtl/ix_pkg.sv
// Shared types and constants for the half-duplex port and its helpers.
package ix_pkg;

    typedef enum logic [1:0] {
        HDP_IDLE  = 2'd0,
        HDP_TURN  = 2'd1,
        HDP_DRIVE = 2'd2,
        HDP_SENSE = 2'd3
    } hdp_state_t;

    // Same encoding as the switch benches: 0 = left-to-right (we drive), 1 = right-to-left.
    localparam logic HDP_DIR_TX = 1'b0;
    localparam logic HDP_DIR_RX = 1'b1;

    function automatic int unsigned hdp_cnt_width(input int unsigned turn_cycles,
                                                  input int unsigned settle_cycles);
        int unsigned m;
        m = (turn_cycles > settle_cycles) ? turn_cycles : settle_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/half_duplex_port_if.sv
// Fabric-side streams plus pad/switch controls of one half-duplex port.
interface half_duplex_port_if #(
    parameter int unsigned W = 1
);
    logic         en;
    logic         dir;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic [W-1:0] pad_o;
    logic         pad_oe;
    logic [W-1:0] pad_i;
    logic         sw_en;
    logic         busy_turn;

    // Fabric / net side drives the requests and sensed value.
    modport master (
        output en, dir, tx_data, tx_valid, pad_i,
        input  tx_ready, rx_data, rx_valid, pad_o, pad_oe, sw_en, busy_turn
    );

    // The port itself.
    modport slave (
        input  en, dir, tx_data, tx_valid, pad_i,
        output tx_ready, rx_data, rx_valid, pad_o, pad_oe, sw_en, busy_turn
    );
endinterface

// File: rtl/hdp_phase_counter.sv
// Saturating down-counter shared by the turnaround and settle timing.
module hdp_phase_counter #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    input  logic            dec,
    output logic            done
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/half_duplex_port.sv
// One end of a switched bidirectional net: sequences IDLE/TURN/DRIVE/SENSE so the
// local driver and the far end are never connected while both could drive.
module half_duplex_port
    import ix_pkg::*;
#(
    parameter int unsigned W             = 1,
    parameter int unsigned TURN_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    half_duplex_port_if.slave bus
);

    localparam int unsigned     CntW       = hdp_cnt_width(TURN_CYCLES, SETTLE_CYCLES);
    localparam logic [CntW-1:0] TurnLoad   = CntW'(TURN_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES);

    hdp_state_t      state_q;
    logic [W-1:0]    pad_o_q;
    logic            pad_oe_q;
    logic            sw_en_q;
    logic [W-1:0]    rx_data_q;
    logic            rx_valid_q;
    logic            busy_turn_q;

    logic            cnt_load;
    logic            cnt_dec;
    logic [CntW-1:0] cnt_load_val;
    logic            cnt_done;

    logic            exit_drive;
    logic            exit_sense;
    logic            tx_ready;

    assign exit_drive = !bus.en || (bus.dir != HDP_DIR_TX);
    assign exit_sense = !bus.en || (bus.dir != HDP_DIR_RX);
    assign tx_ready   = (state_q == HDP_DRIVE) && bus.en && (bus.dir == HDP_DIR_TX);

    hdp_phase_counter #(
        .CntW (CntW)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Loading TURN_CYCLES-1 makes TURN last exactly TURN_CYCLES cycles incl. the done cycle.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = TurnLoad;
        unique case (state_q)
            HDP_IDLE: cnt_load = bus.en;
            HDP_TURN: begin
                if (!cnt_done) begin
                    cnt_dec = 1'b1;
                end else if (bus.en && (bus.dir == HDP_DIR_RX)) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = SettleLoad;
                end
            end
            HDP_DRIVE: cnt_load = exit_drive;
            HDP_SENSE: begin
                if (exit_sense) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = !cnt_done;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDP_IDLE;
            pad_o_q     <= '0;
            pad_oe_q    <= 1'b0;
            sw_en_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_turn_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                HDP_IDLE: begin
                    if (bus.en) begin
                        state_q     <= HDP_TURN;
                        busy_turn_q <= 1'b1;
                    end
                end
                HDP_TURN: begin
                    // en/dir only matter on the final turnaround cycle.
                    if (cnt_done) begin
                        busy_turn_q <= 1'b0;
                        if (!bus.en) begin
                            state_q <= HDP_IDLE;
                        end else if (bus.dir == HDP_DIR_TX) begin
                            state_q  <= HDP_DRIVE;
                            pad_oe_q <= 1'b1;
                            sw_en_q  <= 1'b1;
                        end else begin
                            state_q <= HDP_SENSE;
                            sw_en_q <= 1'b1;
                        end
                    end
                end
                HDP_DRIVE: begin
                    if (exit_drive) begin
                        state_q     <= HDP_TURN;
                        pad_oe_q    <= 1'b0;
                        sw_en_q     <= 1'b0;
                        busy_turn_q <= 1'b1;
                    end else if (bus.tx_valid) begin
                        pad_o_q <= bus.tx_data;
                    end
                end
                HDP_SENSE: begin
                    if (exit_sense) begin
                        state_q     <= HDP_TURN;
                        sw_en_q     <= 1'b0;
                        busy_turn_q <= 1'b1;
                    end else if (cnt_done) begin
                        rx_data_q  <= bus.pad_i;
                        rx_valid_q <= 1'b1;
                    end
                end
                default: state_q <= HDP_IDLE;
            endcase
        end
    end

    assign bus.tx_ready  = tx_ready;
    assign bus.pad_o     = pad_o_q;
    assign bus.pad_oe    = pad_oe_q;
    assign bus.sw_en     = sw_en_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy_turn = busy_turn_q;

    // The switch must be open and the driver off for the whole turnaround.
    a_turn_quiet: assert property (@(posedge clk) disable iff (reset)
        busy_turn_q |-> (!sw_en_q && !pad_oe_q));

    a_oe_only_with_switch: assert property (@(posedge clk) disable iff (reset)
        pad_oe_q |-> (sw_en_q && (state_q == HDP_DRIVE)));

endmodule

// File: tb/tb_half_duplex_port.sv
// Self-checking bench: one port with a bench-driven net, plus two ports joined by a pass switch.
module tb_half_duplex_port;
    import ix_pkg::*;

    localparam int unsigned W      = 8;
    localparam int unsigned TURN   = 2;
    localparam int unsigned SETTLE = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    half_duplex_port_if #(.W(W)) bus   ();
    half_duplex_port_if #(.W(W)) bus_a ();
    half_duplex_port_if #(.W(W)) bus_b ();

    half_duplex_port #(.W(W), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    half_duplex_port #(.W(W), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    half_duplex_port #(.W(W), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Behavioural stand-in for the tranif1 joining the two segment ends.
    logic sw_closed;
    assign sw_closed   = bus_a.sw_en & bus_b.sw_en;
    assign bus_a.pad_i = (sw_closed && bus_b.pad_oe) ? bus_b.pad_o
                       : (bus_a.pad_oe ? bus_a.pad_o : '0);
    assign bus_b.pad_i = (sw_closed && bus_a.pad_oe) ? bus_a.pad_o
                       : (bus_b.pad_oe ? bus_b.pad_o : '0);

    logic [W-1:0] q_rx[$];
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic         pair_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_single();
        logic [W-1:0] exp;
        if (bus.rx_valid) begin
            if (q_rx.size() == 0) begin
                check_eq("rx_unexpected", 32'd1, 32'd0);
            end else begin
                exp = q_rx.pop_front();
                check_eq("rx_data", 32'(bus.rx_data), 32'(exp));
            end
        end
    endtask

    // Receiver samples every SENSE cycle, so a held word repeats; a new word must match the head.
    task automatic mon_pair();
        logic [W-1:0] exp;
        check_eq("contention", 32'(bus_a.pad_oe & bus_b.pad_oe & (bus_a.sw_en | bus_b.sw_en)), 32'd0);
        if (bus_a.rx_valid) begin
            if (q_a.size() > 0 && bus_a.rx_data == q_a[0]) begin
                exp    = q_a.pop_front();
                last_a = exp;
            end else begin
                exp = last_a;
            end
            check_eq("rx_a", 32'(bus_a.rx_data), 32'(exp));
        end
        if (bus_b.rx_valid) begin
            if (q_b.size() > 0 && bus_b.rx_data == q_b[0]) begin
                exp    = q_b.pop_front();
                last_b = exp;
            end else begin
                exp = last_b;
            end
            check_eq("rx_b", 32'(bus_b.rx_data), 32'(exp));
        end
    endtask

    always @(negedge clk) mon_single();
    always @(negedge clk) if (pair_on) mon_pair();

    task automatic send(input bit a_tx, input logic [W-1:0] w);
        if (a_tx) begin
            bus_a.tx_valid = 1'b1;
            bus_a.tx_data  = w;
            q_b.push_back(w);
            #1 check_eq("tx_ready_a", 32'(bus_a.tx_ready), 32'd1);
        end else begin
            bus_b.tx_valid = 1'b1;
            bus_b.tx_data  = w;
            q_a.push_back(w);
            #1 check_eq("tx_ready_b", 32'(bus_b.tx_ready), 32'd1);
        end
        wait_neg(1);
        bus_a.tx_valid = 1'b0;
        bus_b.tx_valid = 1'b0;
    endtask

    task automatic run_phase(input bit a_tx, input logic [W-1:0] w0, input logic [W-1:0] w1);
        bus_a.en  = 1'b1;
        bus_b.en  = 1'b1;
        bus_a.dir = a_tx ? HDP_DIR_TX : HDP_DIR_RX;
        bus_b.dir = a_tx ? HDP_DIR_RX : HDP_DIR_TX;
        wait_neg(TURN + 1);
        send(a_tx, w0);
        wait_neg(1);
        send(a_tx, w1);
        wait_neg(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.en = 1'b0;   bus.dir = HDP_DIR_TX;   bus.tx_valid = 1'b0;
        bus.tx_data = '0; bus.pad_i = '0;
        bus_a.en = 1'b0; bus_a.dir = HDP_DIR_TX; bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
        bus_b.en = 1'b0; bus_b.dir = HDP_DIR_RX; bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
        wait_neg(2);
        check_eq("rst_pad_oe",    32'(bus.pad_oe),    32'd0);
        check_eq("rst_sw_en",     32'(bus.sw_en),     32'd0);
        check_eq("rst_pad_o",     32'(bus.pad_o),     32'd0);
        check_eq("rst_rx_data",   32'(bus.rx_data),   32'd0);
        check_eq("rst_rx_valid",  32'(bus.rx_valid),  32'd0);
        check_eq("rst_busy_turn", 32'(bus.busy_turn), 32'd0);
        check_eq("rst_tx_ready",  32'(bus.tx_ready),  32'd0);
        reset = 1'b0;

        // Reset asserted mid-DRIVE clears the drive before the next edge.
        bus.en = 1'b1; bus.dir = HDP_DIR_TX;
        wait_neg(TURN + 1);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hA5;
        wait_neg(1);
        bus.tx_valid = 1'b0;
        check_eq("pre_rst_pad_o",  32'(bus.pad_o),  32'hA5);
        check_eq("pre_rst_pad_oe", 32'(bus.pad_oe), 32'd1);
        #2 reset = 1'b1; bus.en = 1'b0;
        #1;
        check_eq("async_rst_pad_oe", 32'(bus.pad_oe), 32'd0);
        check_eq("async_rst_sw_en",  32'(bus.sw_en),  32'd0);
        check_eq("async_rst_pad_o",  32'(bus.pad_o),  32'd0);
        wait_neg(1);
        reset = 1'b0;
        wait_neg(1);
        check_eq("idle_busy",  32'(bus.busy_turn), 32'd0);
        check_eq("idle_sw_en", 32'(bus.sw_en),     32'd0);

        // IDLE -> TURN (exactly TURN cycles) -> DRIVE, then one transfer.
        bus.en = 1'b1; bus.dir = HDP_DIR_TX;
        wait_neg(1);
        check_eq("turn1_busy",  32'(bus.busy_turn), 32'd1);
        check_eq("turn1_sw_en", 32'(bus.sw_en),     32'd0);
        wait_neg(1);
        check_eq("turn2_busy",  32'(bus.busy_turn), 32'd1);
        wait_neg(1);
        check_eq("drive_busy",   32'(bus.busy_turn), 32'd0);
        check_eq("drive_pad_oe", 32'(bus.pad_oe),    32'd1);
        check_eq("drive_sw_en",  32'(bus.sw_en),     32'd1);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h3C;
        #1 check_eq("tx_ready_drive", 32'(bus.tx_ready), 32'd1);
        wait_neg(1);
        check_eq("pad_o_3c", 32'(bus.pad_o), 32'h3C);

        // dir flip with a valid word: the flip wins.
        bus.dir = HDP_DIR_RX; bus.tx_data = 8'hFF;
        #1 check_eq("tx_ready_flip", 32'(bus.tx_ready), 32'd0);
        wait_neg(1);
        bus.tx_valid = 1'b0;
        check_eq("flip_pad_o",  32'(bus.pad_o),     32'h3C);
        check_eq("flip_pad_oe", 32'(bus.pad_oe),    32'd0);
        check_eq("flip_sw_en",  32'(bus.sw_en),     32'd0);
        check_eq("flip_busy",   32'(bus.busy_turn), 32'd1);
        wait_neg(1);
        check_eq("flip_turn2_sw_en", 32'(bus.sw_en),     32'd0);
        check_eq("flip_turn2_busy",  32'(bus.busy_turn), 32'd1);
        wait_neg(1);
        check_eq("sense_sw_en",  32'(bus.sw_en),    32'd1);
        check_eq("sense_pad_oe", 32'(bus.pad_oe),   32'd0);
        check_eq("sense_rx_v0",  32'(bus.rx_valid), 32'd0);

        // SENSE: one settle cycle, then one sample per cycle.
        bus.pad_i = 8'h5A;
        wait_neg(1);
        check_eq("settle_rx_v", 32'(bus.rx_valid), 32'd0);
        q_rx.push_back(8'h5A);
        wait_neg(1);
        check_eq("sample1_rx_v", 32'(bus.rx_valid), 32'd1);
        bus.pad_i = 8'h96;
        q_rx.push_back(8'h96);
        wait_neg(1);

        // Leave SENSE while the net changes: last sample holds.
        bus.en = 1'b0; bus.pad_i = 8'h00;
        wait_neg(1);
        check_eq("exit_rx_v",    32'(bus.rx_valid),  32'd0);
        check_eq("exit_rx_data", 32'(bus.rx_data),   32'h96);
        check_eq("exit_busy",    32'(bus.busy_turn), 32'd1);
        check_eq("exit_sw_en",   32'(bus.sw_en),     32'd0);
        wait_neg(TURN);
        check_eq("back_idle_busy", 32'(bus.busy_turn), 32'd0);
        check_eq("hold_rx_data",   32'(bus.rx_data),   32'h96);
        check_eq("rx_q_drained",   32'(q_rx.size()),   32'd0);

        // Two ports through the switch, alternating direction four times.
        pair_on = 1'b1;
        run_phase(1'b1, 8'h11, 8'h22);
        run_phase(1'b0, 8'h33, 8'h44);
        run_phase(1'b1, 8'h55, 8'h66);
        run_phase(1'b0, 8'h77, 8'h88);
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        wait_neg(TURN + 2);
        pair_on = 1'b0;
        check_eq("pair_a_drained", 32'(q_a.size()), 32'd0);
        check_eq("pair_b_drained", 32'(q_b.size()), 32'd0);
        check_eq("pair_a_last",    32'(last_a),     32'h88);
        check_eq("pair_b_last",    32'(last_b),     32'h66);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
